// File: rtl/comparator_sweep_driver.sv
// comparator_sweep_driver: exhaustive (A, B) stimulus engine for an equality
// comparator. Drives every operand pair, waits LAT clocks for the returned EQ,
// scores it against A == B and reports mismatch count, first failing vector
// and per-value equal-case coverage.
module comparator_sweep_driver #(
  parameter int WIDTH = 3,
  parameter int LAT   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      EQ,
  output logic [WIDTH-1:0]          A,
  output logic [WIDTH-1:0]          B,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [2*WIDTH:0]          err_count,
  output logic [WIDTH-1:0]          fail_a,
  output logic [WIDTH-1:0]          fail_b,
  output logic [(1<<WIDTH)-1:0]     eq_hit
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] WC_RELOAD = CW'(LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           vec_q, vec_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic [VW:0]             err_d;
  logic [WIDTH-1:0]        fail_a_d, fail_b_d;
  logic [(1<<WIDTH)-1:0]   eq_hit_d;
  logic                    pass_d;
  logic                    expected;
  logic                    mismatch;

  // The driven operands are fields of the registered vector counter, so A/B
  // are glitch-free register outputs; B is the fast-moving half.
  assign A    = vec_q[VW-1:WIDTH];
  assign B    = vec_q[WIDTH-1:0];
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  // State, counters and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      wcnt_q    <= '0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      eq_hit    <= '0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      wcnt_q    <= wcnt_d;
      err_count <= err_d;
      fail_a    <= fail_a_d;
      fail_b    <= fail_b_d;
      eq_hit    <= eq_hit_d;
      pass      <= pass_d;
    end
  end

  // Next-state, sequencing and scoring logic.
  always_comb begin
    // NOTE: every output of this block gets a hold value first, so no latches.
    state_d  = state_q;
    vec_d    = vec_q;
    wcnt_d   = wcnt_q;
    err_d    = err_count;
    fail_a_d = fail_a;
    fail_b_d = fail_b;
    eq_hit_d = eq_hit;
    pass_d   = pass;

    expected = (A == B);
    // NOTE: case inequality so an X or Z on EQ scores as a mismatch.
    mismatch = (EQ !== expected);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          vec_d    = '0;
          wcnt_d   = WC_RELOAD;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          eq_hit_d = '0;
          pass_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          if (mismatch) begin
            err_d = err_count + 1'b1;
            if (err_count == '0) begin
              fail_a_d = A;
              fail_b_d = B;
            end
          end
          if (expected && (EQ === 1'b1)) begin
            eq_hit_d[A] = 1'b1;
          end
          if (vec_q != '1) begin
            vec_d  = vec_q + 1'b1;
            wcnt_d = WC_RELOAD;
          end else begin
            state_d = S_DONE;
            vec_d   = '0;
            pass_d  = (err_d == '0);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
